seg_digit_counter: RTL
======================

Name: seg_digit_counter

Overview:
- Upstream stage of the 7-segment decoder; produces the 4-bit digit it consumes.
- Programmable prescaler divides clk into a periodic tick; each tick steps a single decimal/hex digit up or down with wrap-around.
- Supports synchronous load of the digit and run-time update of the prescaler compare value.
- All outputs are registered and feed the decoder's digit input directly.

Parameters:
- PRESCALE_W, 24, width of the prescaler counter and compare register.
- DEFAULT_COMPARE, 10000000, compare value after reset (1 tick/s at 10 MHz); must be 1..2^PRESCALE_W-1.
- MAX_DIGIT, 9, highest digit value (9 = decimal, 15 = hex); must be 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; low freezes prescaler and digit.
- up_down  input  1  1 = count up, 0 = count down; sampled on the tick edge.
- load  input  1  synchronous digit load strobe.
- load_value  input  4  value captured on load.
- compare_load  input  1  strobe; capture compare_in as new prescaler period.
- compare_in  input  PRESCALE_W  new period in clk cycles.
- digit  output  4  current digit, to the 7-segment decoder.
- tick  output  1  one-cycle pulse coincident with each digit step.
- wrap  output  1  one-cycle pulse coincident with a wrapping step (MAX_DIGIT->0 up, 0->MAX_DIGIT down).

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (asynchronous assert, effective immediately): digit=0, tick=0, wrap=0, prescaler=0, compare=DEFAULT_COMPARE. Release is synchronous to the next clk edge; counting starts from prescaler=0.
- Prescaler: when en=1, counts 0..compare-1. At the edge where prescaler==compare-1: prescaler<=0, tick<=1, digit<=next(digit). On all other edges: tick<=0.
- Tick period is exactly compare cycles. compare=1 gives tick every enabled cycle.
- Wrap-around: up at MAX_DIGIT -> 0 with wrap<=1; down at 0 -> MAX_DIGIT with wrap<=1. Otherwise ±1 with wrap<=0. wrap is never high without tick.
- Digit values above MAX_DIGIT are unreachable.
- en=0: prescaler and digit hold; tick<=0, wrap<=0. Re-enable resumes from the held prescaler value.
- load=1, highest priority, independent of en:
  - digit<=min(load_value, MAX_DIGIT); prescaler<=0; tick<=0, wrap<=0.
  - A tick due on the same edge is discarded.
- compare_load=1:
  - compare<=(compare_in==0 ? 1 : compare_in).
  - If the current prescaler value is >= the new compare, prescaler<=0 with no tick on that edge.
  - Otherwise the prescaler continues and the new compare applies from that edge.
- compare_load and load on the same edge: both take effect; prescaler<=0.
- compare_load coincident with a due tick (prescaler==old compare-1): the tick is still issued (prescaler<=0, tick<=1).
- Latency: digit, tick and wrap change on the same edge; no extra pipeline stage.

Decomposition:
- Shared package seg_pkg holds:
  - DIGIT_W=4;
  - MAX_DEC=9 and MAX_HEX=15;
  - the direction encoding DIR_UP=1, DIR_DOWN=0.
  The decoder uses the same DIGIT_W.
- One natural sub-module, seg_prescaler:
  - owns the compare register, prescaler counter, clamp-to-1 and the restart rule;
  - inputs: clk, reset, en, clear (driven by load), compare_load, compare_in;
  - output: a single-cycle tick.
- The top level holds the digit register, up/down/wrap logic and the load clamp.

Test Plan:
- Reset and period: reset mid-count (digit=5) -> digit/tick/wrap=0 immediately. Then compare_load with compare_in=4, en=1, up -> tick every 4th cycle; digit 0,1,..,9,0; wrap high only on the 9->0 step.
- Down count: load_value=2, up_down=0, compare=1 -> digit 2,1,0,9,8 on successive cycles; wrap on the 0->9 cycle only.
- Enable freeze: compare=5, drop en after 3 cycles for 10 cycles, then re-raise -> no tick while low; next tick exactly 2 enabled cycles after re-enable.
- Load priority: load=1, load_value=12, MAX_DIGIT=9, on the tick edge -> digit=9, tick=0. Next tick a full compare period later.
- Compare shrink: prescaler at 7 with compare=10, compare_load with compare_in=3 -> prescaler to 0, no tick. Ticks thereafter every 3 cycles.
- Compare zero and hex: compare_in=0 -> tick every enabled cycle. With MAX_DIGIT=15, up -> 14,15,0 with wrap on 15->0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment digit path.
// Holds the digit width used by both the counter and the decoder,
// the decimal/hex maximum digit values, the counting direction encoding
// and the load clamp helper.
package seg_pkg;

  localparam int DIGIT_W  = 4;
  localparam int MAX_DEC  = 9;
  localparam int MAX_HEX  = 15;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Values above the configured maximum are clamped so they can never
  // be presented to the decoder.
  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] value,
    input logic [DIGIT_W-1:0] max_digit
  );
    return (value > max_digit) ? max_digit : value;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Programmable prescaler: divides clk into a periodic single-cycle tick.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   en            - count enable; low holds the counter
//   clear         - restart the period from zero, suppressing any due tick
//   compare_load  - capture compare_in (0 is treated as 1) as the new period
//   compare_in    - new period in clk cycles
//   step          - combinational: a tick is issued on the coming edge
//   tick          - registered one-cycle tick pulse
module seg_prescaler
  import seg_pkg::*;
#(
  parameter int PRESCALE_W      = 24,
  parameter int DEFAULT_COMPARE = 10000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  compare_load,
  input  logic [PRESCALE_W-1:0] compare_in,
  output logic                  step,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] cmp_q, cmp_d;
  logic [PRESCALE_W-1:0] new_cmp;
  logic                  due_old, due_new;
  logic                  tick_q;

  assign new_cmp = (compare_in == '0) ? PRESCALE_W'(1) : compare_in;

  // A tick is due either at the end of the current period, or, on a
  // compare update, at the end of the new period when the counter is
  // already sitting on its last count.
  assign due_old = en && (cnt_q == cmp_q - PRESCALE_W'(1));
  assign due_new = en && compare_load && (cnt_q == new_cmp - PRESCALE_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    cmp_d = cmp_q;
    step  = 1'b0;
    if (compare_load) cmp_d = new_cmp;
    if (clear) begin
      cnt_d = '0;
    end else if (due_old || due_new) begin
      cnt_d = '0;
      step  = 1'b1;
    end else if (compare_load && (cnt_q >= new_cmp)) begin
      // Counter already past the shortened period: restart without a tick.
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      cmp_q  <= PRESCALE_W'(DEFAULT_COMPARE);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      tick_q <= step;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/seg_digit_counter.sv
// Single-digit up/down counter feeding the 7-segment decoder.
// A prescaler tick steps the digit up or down with wrap-around at
// 0 / MAX_DIGIT. Digit, tick and wrap are registered and change together.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   en            - count enable
//   up_down       - 1 up, 0 down
//   load          - load digit (clamped to MAX_DIGIT), restart prescaler
//   load_value    - value captured on load
//   compare_load  - update prescaler period from compare_in
//   compare_in    - new prescaler period
//   digit         - current digit
//   tick          - pulse on every digit step
//   wrap          - pulse on a wrapping step
module seg_digit_counter
  import seg_pkg::*;
#(
  parameter int PRESCALE_W      = 24,
  parameter int DEFAULT_COMPARE = 10000000,
  parameter int MAX_DIGIT       = MAX_DEC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [DIGIT_W-1:0]    load_value,
  input  logic                  compare_load,
  input  logic [PRESCALE_W-1:0] compare_in,
  output logic [DIGIT_W-1:0]    digit,
  output logic                  tick,
  output logic                  wrap
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               wrap_q, wrap_d;
  logic               step;

  seg_prescaler #(
    .PRESCALE_W      (PRESCALE_W),
    .DEFAULT_COMPARE (DEFAULT_COMPARE)
  ) u_prescaler (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .clear        (load),
    .compare_load (compare_load),
    .compare_in   (compare_in),
    .step         (step),
    .tick         (tick)
  );

  always_comb begin
    digit_d = digit_q;
    wrap_d  = 1'b0;
    if (load) begin
      digit_d = clamp_digit(load_value, MAX_D);
    end else if (step) begin
      case (up_down)
        DIR_UP: begin
          if (digit_q >= MAX_D) begin
            digit_d = '0;
            wrap_d  = 1'b1;
          end else begin
            digit_d = digit_q + DIGIT_W'(1);
          end
        end
        DIR_DOWN: begin
          if (digit_q == '0) begin
            digit_d = MAX_D;
            wrap_d  = 1'b1;
          end else begin
            digit_d = digit_q - DIGIT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      wrap_q  <= wrap_d;
    end
  end

  assign digit = digit_q;
  assign wrap  = wrap_q;

endmodule
